// File: rtl/arb_pkg.sv
// Shared constants, state encoding and index decode for the 8-way grant arbiter.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Last-owner value after reset, so requester 0 is searched first.
  localparam logic [IDX_W-1:0] RESET_IDX = 3'd7;

  function automatic logic [NUM_REQ-1:0] idx_decode(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] onehot;
    onehot      = {NUM_REQ{1'b0}};
    onehot[idx] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin priority search: first set request bit at or after start_i, wrapping 7->0.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o
);

  logic                 found_s;
  logic [IDX_W-1:0]     cand_s;

  // Walk the request vector from start_i upward modulo 8 and keep the first hit.
  always_comb begin
    any_o    = |req_i;
    winner_o = start_i;
    found_s  = 1'b0;
    cand_s   = start_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = start_i + IDX_W'(k);
      if (!found_s && req_i[cand_s]) begin
        found_s  = 1'b1;
        winner_o = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

endmodule

// File: rtl/grant_arbiter8.sv
// 8-way round-robin grant arbiter with release/re-arbitration; ARB_TIMEOUT_EN adds hold-limit preemption.
module grant_arbiter8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  arb_state_e           state_q;
  logic [IDX_W-1:0]     grant_idx_q;
  logic                 timeout_q;

  logic                 pick_any_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic [IDX_W-1:0]     search_start_s;
  logic                 release_s;
  logic                 preempt_s;
  logic                 rearb_s;

  // Both IDLE and a releasing owner search from one past the last owner.
  assign search_start_s = grant_idx_q + 3'd1;

  rr_pick8 u_pick (
    .req_i    (req),
    .start_i  (search_start_s),
    .any_o    (pick_any_s),
    .winner_o (pick_idx_s)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt_q;

  // Hold counter restarts on every new grant and counts cycles the owner is kept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q <= 8'd0;
    end else if (rearb_s) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_q + 8'd1;
    end
  end
`else
  logic [7:0] hold_max_unused_s;
  assign hold_max_unused_s = 8'(HOLD_MAX);
`endif

  // Release, preemption and the resulting re-arbitration decision for this cycle.
  always_comb begin
    release_s = done | ~req[grant_idx_q];
    preempt_s = 1'b0;
`ifdef ARB_TIMEOUT_EN
    if (state_q == OWNED) begin
      preempt_s = ~release_s & (hold_cnt_q == HOLD_LAST);
    end else begin
      preempt_s = 1'b0;
    end
`endif
    case (state_q)
      IDLE:    rearb_s = 1'b1;
      OWNED:   rearb_s = release_s | preempt_s;
      default: rearb_s = 1'b1;
    endcase
  end

  // Ownership FSM; a release with any request pending hands over without an idle gap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_idx_q <= RESET_IDX;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= preempt_s;
      case (state_q)
        IDLE: begin
          if (pick_any_s) begin
            state_q     <= OWNED;
            grant_idx_q <= pick_idx_s;
          end else begin
            state_q     <= IDLE;
          end
        end
        OWNED: begin
          if (rearb_s && pick_any_s) begin
            grant_idx_q <= pick_idx_s;
          end else if (rearb_s) begin
            state_q     <= IDLE;
          end else begin
            state_q     <= OWNED;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_valid = (state_q == OWNED);
  assign grant_idx   = grant_idx_q;
  assign grant       = grant_valid ? idx_decode(grant_idx_q) : {NUM_REQ{1'b0}};
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_grant_arbiter8.sv
// Self-checking bench for grant_arbiter8; honours ARB_TIMEOUT_EN (HOLD_MAX=4 when defined).
module tb_grant_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_P = 4;
  localparam bit TO_EN  = 1'b1;
`else
  localparam int HOLD_P = 16;
  localparam bit TO_EN  = 1'b0;
`endif

  logic       clock;
  logic       reset_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int n_checks = 0;
  int n_err    = 0;

  bit m_valid;
  int m_last;
  int m_hold;
  bit m_to;

  grant_arbiter8 #(.HOLD_MAX(HOLD_P)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int rr_next(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      int c = (last + k) % 8;
      if (r[c]) return c;
    end
    return last;
  endfunction

  // Reference model: owner, last owner, cycles held, timeout pulse
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_last  <= 7;
      m_hold  <= 0;
      m_to    <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (!m_valid) begin
        if (req != 8'h00) begin
          m_valid <= 1'b1;
          m_last  <= rr_next(req, m_last);
          m_hold  <= 0;
        end
      end else if (done || !req[m_last] || (TO_EN && m_hold == HOLD_P - 1)) begin
        m_to <= !(done || !req[m_last]);
        if (req != 8'h00) begin
          m_last <= rr_next(req, m_last);
          m_hold <= 0;
        end else begin
          m_valid <= 1'b0;
        end
      end else begin
        m_hold <= m_hold + 1;
      end
    end
  end

  always @(negedge clock) begin
    chk("cyc_grant", grant, m_valid ? (8'h01 << m_last) : 8'h00);
    chk("cyc_idx", grant_idx, m_last);
    chk("cyc_valid", grant_valid, m_valid);
    chk("cyc_timeout", timeout, m_to);
    chk("cyc_onehot0", $onehot0(grant), 1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_own(input string nm, input int idx);
    chk({nm, "_valid"}, grant_valid, 1);
    chk({nm, "_idx"}, grant_idx, idx);
    chk({nm, "_grant"}, grant, 8'h01 << idx);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    req     = 8'h00;
    done    = 1'b0;
    reset_n = 1'b0;
    #12;
    chk("rst_grant", grant, 8'h00);
    chk("rst_valid", grant_valid, 0);
    chk("rst_idx", grant_idx, 3'd7);
    chk("rst_timeout", timeout, 0);
    #10;
    reset_n = 1'b1;
    tick();

    // single requester, then release to IDLE
    req = 8'h04;
    tick();
    expect_own("single", 2);
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("single_rel_valid", grant_valid, 0);
    chk("single_rel_grant", grant, 8'h00);
    chk("single_rel_idx", grant_idx, 3'd2);
    repeat (3) tick();
    chk("idle_hold_idx", grant_idx, 3'd2);

    // rotation with done pulsed every owned cycle
    reset_pulse();
    req = 8'hFF;
    tick();
    expect_own("rot0", 0);
    done = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      expect_own("rot", i % 8);
    end

    // asynchronous reset in the middle of a grant
    done = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_grant", grant, 8'h00);
    chk("midrst_valid", grant_valid, 0);
    chk("midrst_idx", grant_idx, 3'd7);
    chk("midrst_timeout", timeout, 0);
    #1;
    reset_n = 1'b1;

    // wrap / old owner lowest priority
    req = 8'h40;
    tick();
    expect_own("wrap_own6", 6);
    req  = 8'h41;
    done = 1'b1;
    tick();
    expect_own("wrap_to0", 0);
    req  = 8'h40;
    done = 1'b0;
    tick();
    expect_own("wrap_back6", 6);
    done = 1'b1;
    tick();
    expect_own("wrap_regrant6", 6);

    // dropped request acts as a release
    done = 1'b0;
    req  = 8'h08;
    tick();
    expect_own("drop_own3", 3);
    req = 8'h20;
    tick();
    expect_own("drop_to5", 5);
    req = 8'h00;
    tick();
    chk("drop_idle_valid", grant_valid, 0);
    chk("drop_idle_idx", grant_idx, 3'd5);

    // hold limit
    reset_pulse();
    req = 8'h03;
    tick();
    expect_own("hold_own0", 0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_own("hold_keep0", 0);
      chk("hold_no_to", timeout, 0);
    end
    tick();
    chk("hold_to_pulse", timeout, 1);
    expect_own("hold_own1", 1);
    tick();
    chk("hold_to_clear", timeout, 0);
`else
    repeat (120) tick();
    expect_own("hold_keep0", 0);
    chk("hold_no_to", timeout, 0);
`endif
    req = 8'h00;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/grant_arbiter8.md
GRANT_ARBITER8 -- requirements
Module: grant_arbiter8

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16, the maximum number of consecutive cycles one owner may hold the grant (legal range 2..255).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 8 bits: bit i is requester i asking for the shared resource, level-sensitive.
REQ-005 SHALL have port done, input, 1 bit: the current owner releases the resource this cycle; ignored when grant_valid=0.
REQ-006 SHALL have port grant, output, 8 bits: one-hot grant, all zero when no owner.
REQ-007 SHALL have port grant_idx, output, 3 bits: binary index of the owner, and the last owner when grant_valid=0.
REQ-008 SHALL have port grant_valid, output, 1 bit: high while an owner holds the grant.
REQ-009 SHALL have port timeout, output, 1 bit: one-cycle pulse when an owner is preempted by the hold limit.

Function
REQ-010 SHALL implement FSM states IDLE and OWNED; grant_valid=1 exactly in OWNED.
REQ-011 SHALL register all outputs; no combinational path from any input to any output.
REQ-012 SHALL arbitrate round-robin: the search starts at (grant_idx+1) mod 8 and wraps 7->0, and the first set req bit wins.
REQ-013 SHALL, in IDLE with req!=0 at edge N, enter OWNED with the winner visible on grant and grant_idx after edge N (latency 1 cycle).
REQ-014 SHALL stay in IDLE with outputs unchanged while req==0.
REQ-015 SHALL treat release as (done=1) or (req[grant_idx]=0) while in OWNED.
REQ-016 SHALL, on release, re-arbitrate in the same cycle: any req bit set, including the old owner's, makes the next owner take the grant on the next edge with no idle gap; otherwise it goes to IDLE.
REQ-017 SHALL give the old owner lowest priority on release by starting the search at old index+1.
REQ-018 SHALL hold a counter hold_cnt that is 0 on entering OWNED, or on any owner change, and increments each cycle the owner is kept.
REQ-019 SHALL always keep grant exactly one-hot or all zero, and grant SHALL equal decode(grant_idx) whenever grant_valid=1.
REQ-020 SHALL let req bits change while OWNED without disturbing the owner, except as a release under REQ-015.

Reset
REQ-021 SHALL, on reset_n=0, asynchronously force: state IDLE, grant=0, grant_idx=7 (so requester 0 has first priority), grant_valid=0, timeout=0, hold_cnt=0.
REQ-022 SHALL, on reset asserted mid-grant, drop grant immediately without emitting a timeout pulse.
REQ-023 SHALL resume arbitration at the first rising edge after reset_n deasserts.

Configuration
REQ-024 SHALL use macro ARB_TIMEOUT_EN; when defined, an owner not released by hold_cnt==HOLD_MAX-1 is preempted at that edge.
REQ-025 SHALL, on preemption, pulse timeout for one cycle and re-arbitrate per REQ-016/REQ-017; if no other req is pending, the same owner is re-granted with hold_cnt=0.
REQ-026 SHALL, when ARB_TIMEOUT_EN is undefined, hold timeout at 0 and keep an owner until release; the hold counter logic SHALL be absent.

Structure
REQ-027 SHALL place NUM_REQ=8, IDX_W=3 and the state encoding (IDLE=0, OWNED=1) in shared package arb_pkg.
REQ-028 SHALL contain the round-robin priority search in a single sub-module rr_pick8 (inputs req and start index; outputs any and winner index); grant SHALL be decoded from the registered grant_idx.

Verification
REQ-029 SHALL include a reset test: assert reset_n=0 mid-grant -> grant=0, grant_valid=0, grant_idx=7 without waiting for a clock edge.
REQ-030 SHALL include a single-requester test: req=8'h04 from IDLE -> grant=8'h04, grant_idx=2 one edge later; then done=1 -> IDLE next edge.
REQ-031 SHALL include a rotation test: req=8'hFF held, done pulsed each owned cycle -> owners 0,1,...,7,0 with no idle cycle between them.
REQ-032 SHALL include a wrap/priority test: owner 6 releases with req=8'h41 -> next owner 0 (not 6); with req=8'h40 -> owner 6 re-granted.
REQ-033 SHALL include a drop-request test: owner 3, req[3] falls with done=0 and req=8'h20 -> owner 5 on the next edge.
REQ-034 SHALL include a timeout test (ARB_TIMEOUT_EN, HOLD_MAX=4): req=8'h03 held, done=0 -> owner 0 for 4 cycles, then a timeout pulse and owner 1; without the macro, owner 0 holds 100+ cycles and timeout stays 0.
